// File: rtl/led_scan_pkg.sv
// Shared types and constants for the two-panel LED column scanner.
// SCAN_BLANK_EN adds the BLANK state between column slots.
package led_scan_pkg;

    localparam int NUM_COLS        = 8;
    localparam int NUM_PANELS      = 2;
    localparam int SLOTS_PER_FRAME = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SCAN = 2'd1
`ifdef SCAN_BLANK_EN
        ,
        ST_BLANK = 2'd2
`endif
    } scan_state_t;

    typedef enum logic {
        PANEL_X = 1'b0,
        PANEL_Y = 1'b1
    } panel_t;

    // Bits 7:0 map to colx, bits 15:8 to coly, so one shift gives both drives.
    function automatic logic [SLOTS_PER_FRAME-1:0] slot_onehot(input logic [3:0] slot);
        return 16'b1 << slot;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Frame-edit bus of the LED scanner: shadow-frame writes and the commit request.
interface led_scan_ctrl_if;

    // A write transfers on a cycle where wr_valid && wr_ready; the master may hold
    // wr_valid with stable payload until then. commit is a one-cycle request,
    // commit_done a one-cycle pulse returned when the swap is seen on the panels.
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_panel;
    logic [2:0] wr_col;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_done;

    modport master (
        output wr_valid, wr_panel, wr_col, wr_data, commit,
        input  wr_ready, commit_done
    );

    modport slave (
        input  wr_valid, wr_panel, wr_col, wr_data, commit,
        output wr_ready, commit_done
    );

endinterface

// File: rtl/scan_frame_buf.sv
// Shadow/active frame storage (2 panels x 8 columns x 8-bit rows-off masks).
// The read port returns the value the active frame will hold after this edge.
module scan_frame_buf
    import led_scan_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  panel_t     wr_panel,
    input  logic [2:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic       swap,
    input  panel_t     rd_panel,
    input  logic [2:0] rd_col,
    output logic [7:0] rd_data
);

    logic [NUM_PANELS-1:0][NUM_COLS-1:0][7:0] shadow;
    logic [NUM_PANELS-1:0][NUM_COLS-1:0][7:0] shadow_nxt;
    logic [NUM_PANELS-1:0][NUM_COLS-1:0][7:0] active;

    // A write landing in the same cycle as the swap must be part of the new frame.
    always_comb begin
        shadow_nxt = shadow;
        if (wr_en) begin
            shadow_nxt[wr_panel][wr_col] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '1;
            active <= '1;
        end else begin
            shadow <= shadow_nxt;
            if (swap) begin
                active <= shadow_nxt;
            end
        end
    end

    assign rd_data = swap ? shadow_nxt[rd_panel][rd_col] : active[rd_panel][rd_col];

endmodule

// File: rtl/led_scan_ctrl.sv
// Two-panel 8x8 LED column scanner with double-buffered frames.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES dark cycles between column slots.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 16384,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    led_scan_ctrl_if.slave  bus,
    output logic            frame_start,
    output logic [7:0]      row,
    output logic [7:0]      colx,
    output logic [7:0]      coly,
    output scan_state_t     dbg_state
);

    if (DWELL_CYCLES < 2 || DWELL_CYCLES > 65535 ||
        BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_param
        $error("led_scan_ctrl: DWELL_CYCLES or BLANK_CYCLES out of range");
    end

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [3:0]  LAST_SLOT  = 4'(SLOTS_PER_FRAME - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
`endif

    scan_state_t state;
    logic [3:0]  slot;
    logic [15:0] dwell;
    logic        commit_pending;

    logic        wr_fire;
    logic        commit_req;
    logic        slot_tc;
    logic        frame_end;
    logic        enter_slot;
    logic        swap;
    logic [3:0]  nxt_slot;
    logic [15:0] nxt_onehot;
    logic [7:0]  rd_data;

    assign wr_fire    = bus.wr_valid && bus.wr_ready;
    assign commit_req = commit_pending || bus.commit;
    assign slot_tc    = (state == ST_SCAN) && (dwell == DWELL_LAST);

    // In BLANK the slot register still names the slot just finished.
`ifdef SCAN_BLANK_EN
    logic blank_tc;
    assign blank_tc   = (state == ST_BLANK) && (dwell == BLANK_LAST);
    assign frame_end  = blank_tc && (slot == LAST_SLOT);
    assign enter_slot = ((state == ST_OFF) && swap) || blank_tc;
`else
    assign frame_end  = slot_tc && (slot == LAST_SLOT);
    assign enter_slot = ((state == ST_OFF) && swap) || slot_tc;
`endif

    assign swap       = commit_req && ((state == ST_OFF) || frame_end);
    assign nxt_slot   = (state == ST_OFF) ? 4'd0 : slot + 4'd1;
    assign nxt_onehot = slot_onehot(nxt_slot);
    assign dbg_state  = state;

    scan_frame_buf u_frame_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_fire),
        .wr_panel (panel_t'(bus.wr_panel)),
        .wr_col   (bus.wr_col),
        .wr_data  (bus.wr_data),
        .swap     (swap),
        .rd_panel (panel_t'(nxt_slot[3])),
        .rd_col   (nxt_slot[2:0]),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_OFF;
            slot            <= 4'd0;
            dwell           <= 16'd0;
            commit_pending  <= 1'b0;
            row             <= 8'hFF;
            colx            <= 8'h00;
            coly            <= 8'h00;
            bus.wr_ready    <= 1'b1;
            bus.commit_done <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            frame_start     <= 1'b0;
            bus.commit_done <= swap;
            commit_pending  <= commit_req && !swap;
            bus.wr_ready    <= swap || !commit_req;
            if (enter_slot) begin
                state        <= ST_SCAN;
                slot         <= nxt_slot;
                dwell        <= 16'd0;
                row          <= rd_data;
                {coly, colx} <= nxt_onehot;
                frame_start  <= (nxt_slot == 4'd0);
            end
`ifdef SCAN_BLANK_EN
            else if (slot_tc) begin
                state <= ST_BLANK;
                dwell <= 16'd0;
                row   <= 8'hFF;
                colx  <= 8'h00;
                coly  <= 8'h00;
            end
`endif
            else if (state != ST_OFF) begin
                dwell <= dwell + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl against a frame-position reference model.
// Honours SCAN_BLANK_EN the same way as the design.
`timescale 1ns/1ps
module tb_led_scan_ctrl;
    import led_scan_pkg::*;

    localparam int D  = 2;
    localparam int BL = 3;
`ifdef SCAN_BLANK_EN
    localparam int B = BL;
`else
    localparam int B = 0;
`endif
    localparam int P     = D + B;
    localparam int FRAME = 16 * P;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start;
    logic [7:0]  row, colx, coly;
    scan_state_t dbg_state;

    led_scan_ctrl_if bus();

    led_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .frame_start (frame_start),
        .row         (row),
        .colx        (colx),
        .coly        (coly),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is a timeline of 16*P cycles; position m_t
    // gives slot = m_t / P, and the tail of each slot (>= D) is dark.
    logic [7:0] m_shadow [2][8];
    logic [7:0] m_active [2][8];
    bit         m_running, m_pending, m_swapped;
    int         m_t;
    logic [7:0] exp_row, exp_colx, exp_coly;
    logic       exp_ready, exp_done, exp_fs;

    function automatic void model_outputs();
        int s, w;
        exp_ready = !m_pending;
        exp_done  = m_swapped;
        exp_fs    = m_running && (m_t == 0);
        exp_row   = 8'hFF;
        exp_colx  = 8'h00;
        exp_coly  = 8'h00;
        if (m_running) begin
            s = m_t / P;
            w = m_t % P;
            if (w < D) begin
                exp_row = m_active[s / 8][s % 8];
                if (s < 8) exp_colx = 8'(1 << s);
                else       exp_coly = 8'(1 << (s - 8));
            end
        end
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 8; c++) begin
                m_shadow[p][c] = 8'hFF;
                m_active[p][c] = 8'hFF;
            end
        end
        m_running = 0;
        m_pending = 0;
        m_swapped = 0;
        m_t       = 0;
        model_outputs();
    endfunction

    function automatic void model_edge();
        bit req;
        m_swapped = 0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (bus.wr_valid && exp_ready) m_shadow[bus.wr_panel][bus.wr_col] = bus.wr_data;
        req       = m_pending || bus.commit;
        m_pending = req;
        if (!m_running) begin
            if (req) begin
                m_running = 1;
                m_t       = 0;
                m_active  = m_shadow;
                m_pending = 0;
                m_swapped = 1;
            end
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0;
                if (req) begin
                    m_active  = m_shadow;
                    m_pending = 0;
                    m_swapped = 1;
                end
            end
        end
        model_outputs();
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.wr_valid = 1'b0;
        bus.wr_panel = 1'b0;
        bus.wr_col   = 3'd0;
        bus.wr_data  = 8'h00;
        bus.commit   = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        model_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (row !== 8'hFF || colx !== 8'h00 || coly !== 8'h00 || bus.wr_ready !== 1'b1 ||
            bus.commit_done !== 1'b0 || frame_start !== 1'b0 || dbg_state !== ST_OFF) begin
            errors++;
            $display("FAIL reset_vals: row=%h colx=%h coly=%h rdy=%b done=%b fs=%b st=%0d, want FF 00 00 1 0 0 OFF",
                     row, colx, coly, bus.wr_ready, bus.commit_done, frame_start, dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (row !== 8'hFF || colx !== 8'h00 || coly !== 8'h00 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL idle_off cyc %0d: row=%h colx=%h coly=%h fs=%b, want FF 00 00 0",
                         i, row, colx, coly, frame_start);
            end
        end
    endtask

    task automatic test_first_commit();
        bus.wr_valid = 1'b1;
        bus.wr_panel = 1'b0;
        bus.wr_col   = 3'd0;
        bus.wr_data  = 8'h7E;
        bus.commit   = 1'b1;
        tick();
        set_idle();
        checks++;
        if (bus.commit_done !== 1'b1 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL first_done: done=%b fs=%b, want 1 1", bus.commit_done, frame_start);
        end
        checks++;
        if (colx !== 8'h01 || coly !== 8'h00 || row !== 8'h7E) begin
            errors++;
            $display("FAIL first_slot0: colx=%h coly=%h row=%h, want 01 00 7E", colx, coly, row);
        end
        for (int i = 1; i < D; i++) begin
            tick();
            checks++;
            if (colx !== 8'h01 || row !== 8'h7E || bus.commit_done !== 1'b0) begin
                errors++;
                $display("FAIL first_dwell %0d: colx=%h row=%h done=%b, want 01 7E 0", i, colx, row, bus.commit_done);
            end
        end
        for (int i = 0; i < B; i++) begin
            tick();
            checks++;
            if (colx !== 8'h00 || coly !== 8'h00 || row !== 8'hFF) begin
                errors++;
                $display("FAIL first_blank %0d: colx=%h coly=%h row=%h, want 00 00 FF", i, colx, coly, row);
            end
        end
        tick();
        checks++;
        if (colx !== 8'h02 || coly !== 8'h00 || row !== 8'hFF) begin
            errors++;
            $display("FAIL first_slot1: colx=%h coly=%h row=%h, want 02 00 FF", colx, coly, row);
        end
    endtask

    task automatic test_mid_frame_commit();
        bit got;
        got = 0;
        for (int i = 0; i < 2 * FRAME && m_t != 5 * P; i++) tick();
        checks++;
        if (m_t != 5 * P || colx !== 8'h20) begin
            errors++;
            $display("FAIL mid_reach_slot5: colx=%h, want 20", colx);
        end
        bus.wr_valid = 1'b1;
        bus.wr_panel = 1'b0;
        bus.wr_col   = 3'd0;
        bus.wr_data  = 8'h00;
        bus.commit   = 1'b1;
        tick();
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            // Refused edit and an ignored second commit while the swap is pending.
            bus.wr_valid = i[0];
            bus.wr_data  = 8'hAA;
            bus.commit   = ~i[0];
            checks++;
            if (bus.wr_ready !== 1'b0 || row !== exp_row || colx !== exp_colx || coly !== exp_coly) begin
                errors++;
                $display("FAIL mid_pending %0d: rdy=%b row=%h colx=%h coly=%h, want 0 %h %h %h",
                         i, bus.wr_ready, row, colx, coly, exp_row, exp_colx, exp_coly);
            end
            tick();
            got = m_swapped;
        end
        set_idle();
        checks++;
        if (!got || row !== 8'h00 || colx !== 8'h01 || bus.commit_done !== 1'b1 ||
            frame_start !== 1'b1 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_swap: seen=%0d row=%h colx=%h done=%b fs=%b rdy=%b, want 1 00 01 1 1 1",
                     got, row, colx, bus.commit_done, frame_start, bus.wr_ready);
        end
    endtask

    task automatic test_full_frame();
        logic [15:0] exp_q[$];
        logic [15:0] cur, last;
        int          zero_run, len;
        bit          seen_fs, next_fs;
        seen_fs = 0;
        next_fs = 0;
        set_idle();
        for (int i = 0; i < 2 * FRAME && !seen_fs; i++) begin
            tick();
            seen_fs = (frame_start === 1'b1);
        end
        checks++;
        if (!seen_fs) begin
            errors++;
            $display("FAIL frame_start_wait: no frame_start within %0d cycles", 2 * FRAME);
        end
        for (int s = 0; s < 16; s++) exp_q.push_back(16'd1 << s);
        exp_q.push_back(16'd1);
        last = {coly, colx};
        checks++;
        if (last !== exp_q[0]) begin
            errors++;
            $display("FAIL walk_first: got %h want %h", last, exp_q[0]);
        end
        void'(exp_q.pop_front());
        zero_run = 0;
        len      = 0;
        for (int i = 0; i < FRAME + 2 * P && !next_fs; i++) begin
            tick();
            len++;
            cur = {coly, colx};
            checks++;
            if (colx !== 8'h00 && coly !== 8'h00) begin
                errors++;
                $display("FAIL walk_both: colx=%h coly=%h, want one zero", colx, coly);
            end
            if (cur == 16'd0) begin
                zero_run++;
            end else if (cur != last) begin
                checks++;
                if (exp_q.size() == 0 || cur !== exp_q[0] || zero_run != B) begin
                    errors++;
                    $display("FAIL walk_step: got %h after %0d dark, want %h after %0d dark",
                             cur, zero_run, (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, B);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                zero_run = 0;
                last     = cur;
            end
            next_fs = (frame_start === 1'b1);
        end
        checks++;
        if (!next_fs || len != FRAME || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_len: got %0d cycles (%0d slots left), want %0d (0)", len, exp_q.size(), FRAME);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8 * FRAME; i++) begin
            bus.wr_valid = ($urandom_range(0, 1) == 1);
            bus.wr_panel = 1'($urandom_range(0, 1));
            bus.wr_col   = 3'($urandom_range(0, 7));
            bus.wr_data  = 8'($urandom);
            bus.commit   = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (row !== exp_row || colx !== exp_colx || coly !== exp_coly || bus.wr_ready !== exp_ready ||
                bus.commit_done !== exp_done || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL rand %0d: row=%h colx=%h coly=%h rdy=%b done=%b fs=%b, want %h %h %h %b %b %b",
                         i, row, colx, coly, bus.wr_ready, bus.commit_done, frame_start,
                         exp_row, exp_colx, exp_coly, exp_ready, exp_done, exp_fs);
            end
        end
        set_idle();
    endtask

    task automatic test_reset_mid_commit();
        set_idle();
        for (int i = 0; i < 2 * FRAME && m_t != 7 * P; i++) tick();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        for (int i = 0; i < 2 * FRAME && m_t != 9 * P + 1; i++) tick();
        checks++;
        if (bus.wr_ready !== 1'b0 || coly !== 8'h02) begin
            errors++;
            $display("FAIL rst_setup: rdy=%b coly=%h, want 0 02", bus.wr_ready, coly);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (row !== 8'hFF || colx !== 8'h00 || coly !== 8'h00 || bus.wr_ready !== 1'b1 ||
            bus.commit_done !== 1'b0 || frame_start !== 1'b0 || dbg_state !== ST_OFF) begin
            errors++;
            $display("FAIL rst_async: row=%h colx=%h coly=%h rdy=%b done=%b fs=%b st=%0d, want FF 00 00 1 0 0 OFF",
                     row, colx, coly, bus.wr_ready, bus.commit_done, frame_start, dbg_state);
        end
        model_reset();
        tick();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3 * P; i++) begin
            tick();
            checks++;
            if (dbg_state !== ST_OFF || bus.wr_ready !== 1'b1 || row !== 8'hFF || colx !== 8'h00 || coly !== 8'h00) begin
                errors++;
                $display("FAIL rst_off %0d: st=%0d rdy=%b row=%h colx=%h coly=%h, want OFF 1 FF 00 00",
                         i, dbg_state, bus.wr_ready, row, colx, coly);
            end
        end
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        checks++;
        if (bus.commit_done !== 1'b1 || colx !== 8'h01 || row !== 8'hFF) begin
            errors++;
            $display("FAIL rst_discard: done=%b colx=%h row=%h, want 1 01 FF", bus.commit_done, colx, row);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (row !== exp_row || colx !== exp_colx || coly !== exp_coly || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL rst_frame %0d: row=%h colx=%h coly=%h fs=%b, want %h %h %h %b",
                         i, row, colx, coly, frame_start, exp_row, exp_colx, exp_coly, exp_fs);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_commit();
        test_mid_frame_commit();
        test_full_frame();
        test_random();
        test_reset_mid_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
